// File: rtl/cont_pkg.sv
// Shared definitions for the parametrised mode counter: mode encodings and
// a helper that derives the all-ones count limit from a width.
package cont_pkg;

   localparam logic [1:0] MODO_UP     = 2'b00;
   localparam logic [1:0] MODO_DN     = 2'b01;
   localparam logic [1:0] MODO_DNSTEP = 2'b10;
   localparam logic [1:0] MODO_LOAD   = 2'b11;

   // Largest count representable in w bits (valid for w < 64).
   function automatic longint unsigned max_of(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/cont_next.sv
// Combinational next-state for the mode counter: new count plus the
// wrap/limit event that the top module registers as rco.
module cont_next
   import cont_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int DN_STEP = 3,
   parameter bit SAT     = 1'b0
) (
   input  logic [WIDTH-1:0] Q,
   input  logic [1:0]       modo,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] q_nxt,
   output logic             carry_nxt
);

   localparam logic [WIDTH-1:0] MAX  = WIDTH'(max_of(WIDTH));
   localparam logic [WIDTH:0]   STEP = (WIDTH+1)'(DN_STEP);

   // One extra bit so the top bit of the difference is the borrow (Q < DN_STEP).
   logic [WIDTH:0] diff;
   assign diff = {1'b0, Q} - STEP;

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch.
      q_nxt     = Q;
      carry_nxt = 1'b0;
      case (modo)
         MODO_UP: begin
            if (Q == MAX) begin
               carry_nxt = 1'b1;
               q_nxt     = SAT ? MAX : '0;
            end else begin
               q_nxt = Q + 1'b1;
            end
         end
         MODO_DN: begin
            if (Q == '0) begin
               carry_nxt = 1'b1;
               q_nxt     = SAT ? '0 : MAX;
            end else begin
               q_nxt = Q - 1'b1;
            end
         end
         MODO_DNSTEP: begin
            if (diff[WIDTH]) begin
               carry_nxt = 1'b1;
               q_nxt     = SAT ? '0 : diff[WIDTH-1:0];
            end else begin
               q_nxt = diff[WIDTH-1:0];
            end
         end
         default: q_nxt = D;
      endcase
   end

endmodule

// File: rtl/cont_param.sv
// WIDTH-bit four-mode counter with registered ripple-carry out, cascade
// carry-in and a sticky overflow flag; synchronous active-low reset.
module cont_param
   import cont_pkg::*;
#(
   parameter int          WIDTH   = 4,
   parameter int          DN_STEP = 3,
   parameter bit          SAT     = 1'b0,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             enb,
   input  logic             rci,
   input  logic [1:0]       modo,
   input  logic [WIDTH-1:0] D,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] Q,
   output logic             rco,
   output logic             ovf
);

   logic             act;
   logic [WIDTH-1:0] q_nxt;
   logic             carry_nxt;
   logic             rco_nxt;

   assign act     = enb & rci;
   assign rco_nxt = act & carry_nxt;

   cont_next #(
      .WIDTH   (WIDTH),
      .DN_STEP (DN_STEP),
      .SAT     (SAT)
   ) u_next (
      .Q         (Q),
      .modo      (modo),
      .D         (D),
      .q_nxt     (q_nxt),
      .carry_nxt (carry_nxt)
   );

   // rco is registered on the same edge as Q, so it lines up with the wrapped value.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep all three registers sampling pre-edge values.
      if (!reset_L) begin
         Q   <= WIDTH'(RST_VAL);
         rco <= 1'b0;
         ovf <= 1'b0;
      end else begin
         if (act) Q <= q_nxt;
         rco <= rco_nxt;
         ovf <= (ovf & ~clr_ovf) | rco_nxt;
      end
   end

endmodule

// File: tb/tb_cont_param.sv
// Directed self-checking bench for cont_param: wrap and saturating variants
// driven in lockstep, plus a two-stage cascade.
module tb_cont_param;
   import cont_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_L, enb, rci, clr_ovf, c_enb;
   logic [1:0] modo;
   logic [3:0] D;

   logic [3:0] q_w, q_s, q_lo, q_hi;
   logic       rco_w, ovf_w, rco_s, ovf_s, rco_lo, ovf_lo, rco_hi, ovf_hi;

   int checks = 0;
   int errors = 0;

   cont_param #(.WIDTH(4), .DN_STEP(3), .SAT(1'b0), .RST_VAL(0)) dut_wrap (
      .clk(clk), .reset_L(reset_L), .enb(enb), .rci(rci), .modo(modo), .D(D),
      .clr_ovf(clr_ovf), .Q(q_w), .rco(rco_w), .ovf(ovf_w));

   cont_param #(.WIDTH(4), .DN_STEP(3), .SAT(1'b1), .RST_VAL(0)) dut_sat (
      .clk(clk), .reset_L(reset_L), .enb(enb), .rci(rci), .modo(modo), .D(D),
      .clr_ovf(clr_ovf), .Q(q_s), .rco(rco_s), .ovf(ovf_s));

   cont_param #(.WIDTH(4), .DN_STEP(3), .SAT(1'b0), .RST_VAL(0)) dut_lo (
      .clk(clk), .reset_L(reset_L), .enb(c_enb), .rci(1'b1), .modo(modo), .D(D),
      .clr_ovf(clr_ovf), .Q(q_lo), .rco(rco_lo), .ovf(ovf_lo));

   cont_param #(.WIDTH(4), .DN_STEP(3), .SAT(1'b0), .RST_VAL(0)) dut_hi (
      .clk(clk), .reset_L(reset_L), .enb(c_enb), .rci(rco_lo), .modo(modo), .D(D),
      .clr_ovf(clr_ovf), .Q(q_hi), .rco(rco_hi), .ovf(ovf_hi));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the edge; inputs change there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int dn_q[8]  = '{2, 15, 12, 9, 6, 3, 0, 13};
   int dn_r[8]  = '{0, 1, 0, 0, 0, 0, 0, 1};
   int dns_q[8] = '{2, 0, 0, 0, 0, 0, 0, 0};
   int dns_r[8] = '{0, 1, 1, 1, 1, 1, 1, 1};

   // Cascade reference: the high stage advances on the edge after the low stage's rco.
   int m_lo, m_hi;
   bit m_rlo, m_rhi, found;

   task automatic model_cascade();
      bit nrlo, nrhi;
      nrhi = m_rlo && (m_hi == 15);
      if (m_rlo) m_hi = (m_hi + 1) % 16;
      nrlo = (m_lo == 15);
      m_lo = (m_lo + 1) % 16;
      m_rlo = nrlo;
      m_rhi = nrhi;
   endtask

   initial begin
      reset_L = 1'b0; enb = 1'b1; rci = 1'b1; clr_ovf = 1'b0; c_enb = 1'b0;
      modo = MODO_UP; D = 4'd0;
      #1;
      step(); step();
      check("rst_q", q_w, 0);
      check("rst_rco", rco_w, 0);
      check("rst_ovf", ovf_w, 0);

      reset_L = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         check("up_q", q_w, i % 16);
         check("up_rco", rco_w, (i == 16) ? 1 : 0);
         check("up_ovf", ovf_w, (i == 16) ? 1 : 0);
         check("up_sat_q", q_s, (i == 16) ? 15 : i);
         check("up_sat_rco", rco_s, (i == 16) ? 1 : 0);
      end
      step();
      check("ovf_sticky", ovf_w, 1);

      modo = MODO_LOAD; D = 4'd5;
      step();
      check("load5_q", q_w, 5);
      check("load5_rco", rco_w, 0);
      modo = MODO_DNSTEP;
      for (int i = 0; i < 8; i++) begin
         step();
         check("dnstep_q", q_w, dn_q[i]);
         check("dnstep_rco", rco_w, dn_r[i]);
         check("dnstep_sat_q", q_s, dns_q[i]);
         check("dnstep_sat_rco", rco_s, dns_r[i]);
      end

      modo = MODO_LOAD; D = 4'd0;
      step();
      check("load0_q", q_w, 0);
      modo = MODO_DN;
      step();
      check("dn_wrap_q", q_w, 15);
      check("dn_wrap_rco", rco_w, 1);
      check("dn_sat_q", q_s, 0);
      check("dn_sat_rco", rco_s, 1);
      step();
      check("dn_q", q_w, 14);
      check("dn_rco", rco_w, 0);
      check("dn_sat_q2", q_s, 0);
      check("dn_sat_rco2", rco_s, 1);

      modo = MODO_LOAD; D = 4'd7;
      step();
      modo = MODO_UP;
      step();
      check("gate_q1", q_w, 8);
      check("gate_rco1", rco_w, 0);
      rci = 1'b0;
      step();
      check("gate_q2", q_w, 8);
      check("gate_rco2", rco_w, 0);
      rci = 1'b1;
      step();
      check("gate_q3", q_w, 9);
      check("gate_rco3", rco_w, 0);
      enb = 1'b0;
      step();
      check("enb_hold_q", q_w, 9);
      enb = 1'b1;
      modo = MODO_LOAD; D = 4'd15;
      step();
      D = 4'd9;
      step();
      check("load9_q", q_w, 9);
      check("load9_rco", rco_w, 0);

      D = 4'd15;
      step();
      modo = MODO_UP; clr_ovf = 1'b1;
      step();
      check("clr_wrap_q", q_w, 0);
      check("clr_wrap_rco", rco_w, 1);
      check("clr_wrap_ovf", ovf_w, 1);
      step();
      check("clr_ovf", ovf_w, 0);
      clr_ovf = 1'b0;
      step();
      check("ovf_stays_clr", ovf_w, 0);

      reset_L = 1'b0;
      step();
      reset_L = 1'b1; c_enb = 1'b1; modo = MODO_UP;
      m_lo = 0; m_hi = 0; m_rlo = 1'b0; m_rhi = 1'b0;
      for (int i = 1; i <= 272; i++) begin
         step();
         model_cascade();
         check("casc_cnt", {q_hi, q_lo}, (m_hi << 4) | m_lo);
         check("casc_rco_lo", rco_lo, m_rlo);
         check("casc_rco_hi", rco_hi, m_rhi);
      end
      check("casc_ovf_hi", ovf_hi, 1);

      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         model_cascade();
         if (((m_hi << 4) | m_lo) == 'h37) found = 1'b1;
      end
      check("casc_reach_37", found, 1);
      check("casc_at_37", {q_hi, q_lo}, 'h37);
      reset_L = 1'b0;
      step();
      check("casc_rst_lo", q_lo, 0);
      check("casc_rst_hi", q_hi, 0);
      check("casc_rst_rco", rco_hi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
